// File: rtl/select_scan_sequencer_pkg.sv
// Shared definitions for the select scan sequencer.
//   SEL_W        : width of the decoder select (a,b,c)
//   scan_state_e : sequencer states IDLE / RUN / PAUSE
//   next_sel()   : one scan position forward or backward, wrapping inside 0..last
package select_scan_sequencer_pkg;

    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } scan_state_e;

    function automatic logic [SEL_W-1:0] next_sel(
        input logic [SEL_W-1:0] sel,
        input logic             down,
        input logic [SEL_W-1:0] last
    );
        if (down) begin
            return (sel == '0) ? last : sel - 1'b1;
        end
        return (sel == last) ? '0 : sel + 1'b1;
    endfunction

endpackage

// File: rtl/select_scan_sequencer_dwell_timer.sv
// dwell_timer: counts cycles spent on one scan position.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force the count back to 0 (wins over enable)
//   enable     : count this cycle
//   dwell      : extra hold cycles per position
//   reached    : high in the enabled cycle whose count has reached dwell;
//                the count returns to 0 on the following edge
module dwell_timer #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               enable,
    input  logic [DWELL_W-1:0] dwell,
    output logic               reached
);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    // ">=" rather than "==": if dwell is lowered below the running count,
    // the position is released at once instead of counting around.
    assign reached = enable && (cnt_q >= dwell);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = reached ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/select_scan_sequencer.sv
// select_scan_sequencer: drives the 3-bit select of a 3:8 decoder, scanning
// positions 0..LAST_SEL with a programmable dwell, run/pause/step control,
// up/down direction and synchronous load.
//   clk, rst_n       : clock, asynchronous active-low reset
//   start, stop      : run control (IDLE/PAUSE->RUN, RUN->PAUSE->IDLE)
//   step             : one advance per cycle while paused
//   dir              : 0 = up, 1 = down
//   load, load_val   : load select (clamped to LAST_SEL)
//   dwell            : extra hold cycles per position while running
//   a,b,c            : registered select, a = MSB
//   sel_valid, busy  : registered status (valid in RUN/PAUSE, busy in RUN)
//   wrap             : one-cycle pulse while the wrapped value is shown
module select_scan_sequencer
    import select_scan_sequencer_pkg::*;
#(
    parameter int DWELL_W  = 4,
    parameter int LAST_SEL = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               step,
    input  logic               dir,
    input  logic               load,
    input  logic [SEL_W-1:0]   load_val,
    input  logic [DWELL_W-1:0] dwell,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               sel_valid,
    output logic               wrap,
    output logic               busy
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(LAST_SEL);

    scan_state_e       state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              wrap_q, wrap_d;
    logic              sel_valid_q, sel_valid_d;
    logic              busy_q, busy_d;

    logic              tmr_clear;
    logic              tmr_enable;
    logic              tmr_reached;
    logic              advance;

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .dwell   (dwell),
        .reached (tmr_reached)
    );

    // One action per cycle in priority order load > stop > start > advance.
    // stop in IDLE and start in RUN are no-ops and do not mask the lower ones.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        wrap_d     = 1'b0;
        tmr_clear  = 1'b0;
        tmr_enable = 1'b0;
        advance    = 1'b0;

        if (load) begin
            sel_d     = (load_val > LAST) ? LAST : load_val;
            tmr_clear = 1'b1;
        end else if (stop && (state_q != ST_IDLE)) begin
            tmr_clear = 1'b1;
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSE;
            end else begin
                state_d = ST_IDLE;
                sel_d   = '0;
            end
        end else if (start && (state_q != ST_RUN)) begin
            state_d   = ST_RUN;
            tmr_clear = 1'b1;
        end else if (state_q == ST_RUN) begin
            tmr_enable = 1'b1;
            advance    = tmr_reached;
        end else if (state_q == ST_PAUSE) begin
            advance = step;
        end

        if (advance) begin
            sel_d  = next_sel(sel_q, dir, LAST);
            wrap_d = dir ? (sel_q == '0) : (sel_q == LAST);
        end

        sel_valid_d = (state_d != ST_IDLE);
        busy_d      = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            wrap_q      <= 1'b0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            wrap_q      <= wrap_d;
            sel_valid_q <= sel_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign {a, b, c}  = sel_q;
    assign sel_valid  = sel_valid_q;
    assign wrap       = wrap_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_select_scan_sequencer.sv
`timescale 1ns/1ps
module tb_select_scan_sequencer;
    import select_scan_sequencer_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0, stop = 1'b0, step = 1'b0, dir = 1'b0, load = 1'b0;
    logic [SEL_W-1:0] load_val = '0;
    logic [3:0]       dwell = '0;

    logic a7, b7, c7, v7, w7, bz7;
    logic a5, b5, c5, v5, w5, bz5;

    always #5 clk = ~clk;

    select_scan_sequencer #(.DWELL_W(4), .LAST_SEL(7)) u7 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step(step), .dir(dir),
        .load(load), .load_val(load_val), .dwell(dwell),
        .a(a7), .b(b7), .c(c7), .sel_valid(v7), .wrap(w7), .busy(bz7));

    select_scan_sequencer #(.DWELL_W(4), .LAST_SEL(5)) u5 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step(step), .dir(dir),
        .load(load), .load_val(load_val), .dwell(dwell),
        .a(a5), .b(b5), .c(c5), .sel_valid(v5), .wrap(w5), .busy(bz5));

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // st: 0 idle, 1 run, 2 pause. held: cycles already spent on current position in run.
    typedef struct { int st; int sel; int held; bit wrap; } mdl_t;
    mdl_t m7 = '{0, 0, 0, 1'b0};
    mdl_t m5 = '{0, 0, 0, 1'b0};

    function automatic mdl_t mstep(input mdl_t m, input int last, input bit ld, input int lv,
                                   input bit sp, input bit st, input bit stp, input bit dn, input int dw);
        mdl_t r = m;
        bit   adv = 1'b0;
        r.wrap = 1'b0;
        if (ld) begin
            r.sel  = (lv > last) ? last : lv;
            r.held = 0;
        end else if (sp && m.st != 0) begin
            r.held = 0;
            if (m.st == 1) r.st = 2;
            else begin r.st = 0; r.sel = 0; end
        end else if (st && m.st != 1) begin
            r.st   = 1;
            r.held = 0;
        end else if (m.st == 1) begin
            // a position lasts dwell+1 cycles; leave once that many have been spent
            if (m.held + 1 >= dw + 1) begin adv = 1'b1; r.held = 0; end
            else r.held = m.held + 1;
        end else if (m.st == 2 && stp) begin
            adv = 1'b1;
        end
        if (adv) begin
            if (!dn) begin r.sel = (m.sel + 1) % (last + 1); r.wrap = (r.sel == 0); end
            else     begin r.sel = (m.sel + last) % (last + 1); r.wrap = (r.sel == last); end
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m7 <= '{0, 0, 0, 1'b0};
            m5 <= '{0, 0, 0, 1'b0};
        end else begin
            m7 <= mstep(m7, 7, load, int'(load_val), stop, start, step, dir, int'(dwell));
            m5 <= mstep(m5, 5, load, int'(load_val), stop, start, step, dir, int'(dwell));
        end
    end

    task automatic cmp_dut(input string p, input logic [2:0] s, input logic v, input logic w,
                           input logic bz, input mdl_t m);
        check({p, ".sel"},   32'(s),  32'(m.sel));
        check({p, ".valid"}, 32'(v),  32'(m.st != 0));
        check({p, ".wrap"},  32'(w),  32'(m.wrap));
        check({p, ".busy"},  32'(bz), 32'(m.st == 1));
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp_dut("u7", {a7, b7, c7}, v7, w7, bz7, m7);
            cmp_dut("u5", {a5, b5, c5}, v5, w5, bz5, m5);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int exp5 [6] = '{4, 3, 2, 1, 0, 5};

    initial begin
        cyc(2);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        check("rst.sel",   32'({a7, b7, c7}), 32'd0);
        check("rst.valid", 32'(v7), 32'd0);
        check("rst.busy",  32'(bz7), 32'd0);
        check("rst.wrap",  32'(w7), 32'd0);

        // free run, dwell 0, up
        start = 1'b1; cyc(1); start = 1'b0;
        check("run.sel0", 32'({a7, b7, c7}), 32'd0);
        check("run.busy", 32'(bz7), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            cyc(1);
            check($sformatf("run.sel%0d", i), 32'({a7, b7, c7}), 32'(i % 8));
            check($sformatf("run.wrap%0d", i), 32'(w7), 32'(i == 8));
            check($sformatf("run.valid%0d", i), 32'(v7), 32'd1);
        end

        // pause and single step
        load = 1'b1; load_val = 3'd3; cyc(1); load = 1'b0;
        check("pause.load3", 32'({a7, b7, c7}), 32'd3);
        stop = 1'b1; cyc(1); stop = 1'b0;
        check("pause.sel", 32'({a7, b7, c7}), 32'd3);
        check("pause.busy", 32'(bz7), 32'd0);
        check("pause.valid", 32'(v7), 32'd1);
        step = 1'b1; cyc(1);
        check("step.sel4", 32'({a7, b7, c7}), 32'd4);
        cyc(1); step = 1'b0;
        check("step.sel5", 32'({a7, b7, c7}), 32'd5);
        stop = 1'b1; cyc(1); stop = 1'b0;
        check("idle.sel", 32'({a7, b7, c7}), 32'd0);
        check("idle.valid", 32'(v7), 32'd0);

        // reset mid-run at sel 5
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(5);
        check("mid.sel5", 32'({a7, b7, c7}), 32'd5);
        rst_n = 1'b0; #1;
        check("arst.sel", 32'({a7, b7, c7}), 32'd0);
        check("arst.valid", 32'(v7), 32'd0);
        check("arst.busy", 32'(bz7), 32'd0);
        check("arst.wrap", 32'(w7), 32'd0);
        cyc(1); rst_n = 1'b1;

        // dwell 2: three cycles per position, then drop dwell mid-hold
        dwell = 4'd2; start = 1'b1; cyc(1); start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            check($sformatf("dwell.k%0d", k), 32'({a7, b7, c7}), 32'(k / 3));
            cyc(1);
        end
        check("dwell.sel3a", 32'({a7, b7, c7}), 32'd3);
        cyc(1);
        check("dwell.sel3b", 32'({a7, b7, c7}), 32'd3);
        dwell = 4'd0; cyc(1);
        check("dwell.cut", 32'({a7, b7, c7}), 32'd4);

        // priority: load + stop + start in RUN mid-hold
        dwell = 4'd2; load = 1'b1; load_val = 3'd2; cyc(1); load = 1'b0;
        cyc(1);
        check("prio.sel2", 32'({a7, b7, c7}), 32'd2);
        load = 1'b1; stop = 1'b1; start = 1'b1; load_val = 3'd6; cyc(1);
        load = 1'b0; stop = 1'b0; start = 1'b0;
        check("prio.sel6", 32'({a7, b7, c7}), 32'd6);
        check("prio.busy", 32'(bz7), 32'd1);
        cyc(1);
        check("prio.hold1", 32'({a7, b7, c7}), 32'd6);
        cyc(1);
        check("prio.hold2", 32'({a7, b7, c7}), 32'd6);
        cyc(1);
        check("prio.sel7", 32'({a7, b7, c7}), 32'd7);

        // down count with LAST_SEL = 5, clamped load
        dwell = 4'd0; dir = 1'b1; load = 1'b1; load_val = 3'd7; cyc(1); load = 1'b0;
        check("down.clamp5", 32'({a5, b5, c5}), 32'd5);
        check("down.load7", 32'({a7, b7, c7}), 32'd7);
        for (int j = 0; j < 6; j++) begin
            cyc(1);
            check($sformatf("down.sel%0d", j), 32'({a5, b5, c5}), 32'(exp5[j]));
            check($sformatf("down.wrap%0d", j), 32'(w5), 32'(j == 5));
        end

        stop = 1'b1; cyc(2); stop = 1'b0;
        check("end.valid", 32'(v7), 32'd0);
        cyc(1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
